// File: rtl/ram_port_arbiter.sv
// Shares one block RAM (separate read and write ports) between N requesters using two
// independent round-robin arbiters. Optional read-after-write bypass: RAM_ARB_RAW_BYPASS_EN.
module ram_port_arbiter #(
  parameter int W = 8,
  parameter int L = 32,
  parameter int N = 2,
  localparam int AW = $clog2(L),
  localparam int PW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_we,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*W-1:0]  req_wdata,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    rsp_valid,
  output logic [W-1:0]    rsp_data,
  output logic [AW-1:0]   ram_rd_addr,
  input  logic [W-1:0]    ram_rd_data,
  output logic            ram_wr_ena,
  output logic [AW-1:0]   ram_wr_addr,
  output logic [W-1:0]    ram_wr_data
);

  // Returns {found, index}: first candidate at or above ptr, wrapping at N-1 -> 0.
  function automatic logic [PW:0] rr_pick(input logic [N-1:0] cand, input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int j;
    res = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!res[PW] && cand[j]) res = {1'b1, PW'(j)};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] g);
    return (g == PW'(N - 1)) ? '0 : g + 1'b1;
  endfunction

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   rd_pick, wr_pick;
  logic [PW-1:0] rd_idx, wr_idx;
  logic          rd_gnt, wr_gnt;
  logic [N-1:0]  rd_onehot, wr_onehot;
  logic [N-1:0]  rsp_owner;
  logic [AW-1:0] rd_addr_q, rd_addr_sel, wr_addr_sel;
  logic [W-1:0]  wr_data_sel;

  always_comb begin
    rd_pick     = rr_pick(req_valid & ~req_we, rd_ptr);
    wr_pick     = rr_pick(req_valid & req_we, wr_ptr);
    rd_idx      = rd_pick[PW-1:0];
    wr_idx      = wr_pick[PW-1:0];
    // Nothing may be granted while reset is held, even before a clock edge.
    rd_gnt      = rd_pick[PW] & ~rst;
    wr_gnt      = wr_pick[PW] & ~rst;
    rd_onehot   = rd_gnt ? (N'(1) << rd_idx) : '0;
    wr_onehot   = wr_gnt ? (N'(1) << wr_idx) : '0;
    rd_addr_sel = req_addr[rd_idx*AW +: AW];
    wr_addr_sel = req_addr[wr_idx*AW +: AW];
    wr_data_sel = req_wdata[wr_idx*W +: W];
  end

  assign req_ready   = rd_onehot | wr_onehot;
  assign ram_rd_addr = rd_gnt ? rd_addr_sel : rd_addr_q;
  assign ram_wr_ena  = wr_gnt;
  assign ram_wr_addr = wr_gnt ? wr_addr_sel : '0;
  assign ram_wr_data = wr_gnt ? wr_data_sel : '0;
  assign rsp_valid   = rsp_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      rsp_owner <= '0;
      rd_addr_q <= '0;
    end else begin
      rsp_owner <= rd_onehot;
      if (rd_gnt) begin
        rd_ptr    <= ptr_next(rd_idx);
        rd_addr_q <= rd_addr_sel;
      end
      if (wr_gnt) wr_ptr <= ptr_next(wr_idx);
    end
  end

`ifdef RAM_ARB_RAW_BYPASS_EN
  // The RAM is read-first; on a same-address collision return the new data instead.
  logic         byp_q;
  logic [W-1:0] byp_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_q      <= rd_gnt & wr_gnt & (rd_addr_sel == wr_addr_sel);
      byp_data_q <= wr_data_sel;
    end
  end

  assign rsp_data = rst ? '0 : (byp_q ? byp_data_q : ram_rd_data);
`else
  assign rsp_data = rst ? '0 : ram_rd_data;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a read-first block RAM model.
// Build with RAM_ARB_RAW_BYPASS_EN defined to check the bypass variant.
module tb_ram_port_arbiter;
  localparam int W = 8;
  localparam int L = 32;
  localparam int N = 2;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [W-1:0]    rsp_data;
  logic [AW-1:0]   ram_rd_addr;
  logic [W-1:0]    ram_rd_data = 8'h00;
  logic            ram_wr_ena;
  logic [AW-1:0]   ram_wr_addr;
  logic [W-1:0]    ram_wr_data;

  logic [W-1:0] mem [L] = '{1: 8'hB1, 2: 8'hB2, 4: 8'h11, 5: 8'hA5, default: 8'h00};

  int n_tests = 0;
  int n_fail  = 0;

  ram_port_arbiter #(.W(W), .L(L), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .ram_wr_ena (ram_wr_ena),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data)
  );

  always #5 clk = ~clk;

  // Read-first RAM: the read samples the old contents before the write lands.
  always @(posedge clk) begin
    ram_rd_data <= mem[ram_rd_addr];
    if (ram_wr_ena) mem[ram_wr_addr] <= ram_wr_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] coll_exp;

  initial begin
`ifdef RAM_ARB_RAW_BYPASS_EN
    coll_exp = 8'h22;
`else
    coll_exp = 8'h11;
`endif
    rst = 1'b1; req_valid = 2'b11; req_we = 2'b00; req_addr = '0; req_wdata = '0;
    #2;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_rspv",  32'(rsp_valid), 32'h0);
    check("rst_wena",  32'(ram_wr_ena), 32'h0);
    check("rst_rspd",  32'(rsp_data), 32'h0);
    check("rst_rdaddr", 32'(ram_rd_addr), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Round-robin reads: requester 0 reads addr 1, requester 1 reads addr 2
    req_valid = 2'b11; req_we = 2'b00;
    req_addr[0 +: AW] = 5'd1; req_addr[AW +: AW] = 5'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready",  32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("rr_rdaddr", 32'(ram_rd_addr), (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      check("rr_rspv", 32'(rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("rr_rspd", 32'(rsp_data), (k % 2 == 0) ? 32'hB1 : 32'hB2);
    end

    // Single read of row 5 by requester 1
    req_valid = 2'b10; req_addr[AW +: AW] = 5'd5;
    #1;
    check("sr_ready",  32'(req_ready), 32'h2);
    check("sr_rdaddr", 32'(ram_rd_addr), 32'd5);
    tick();
    check("sr_rspv", 32'(rsp_valid), 32'h2);
    check("sr_rspd", 32'(rsp_data), 32'hA5);

    // Idle: read address register holds, no write, no response
    req_valid = 2'b00;
    #1;
    check("idle_ready",  32'(req_ready), 32'h0);
    check("idle_wena",   32'(ram_wr_ena), 32'h0);
    check("idle_wraddr", 32'(ram_wr_addr), 32'h0);
    check("idle_rdaddr", 32'(ram_rd_addr), 32'd5);
    tick();
    check("idle_rspv", 32'(rsp_valid), 32'h0);

    // Concurrent: requester 0 writes 3C to 7, requester 1 reads 9
    req_valid = 2'b11; req_we = 2'b01;
    req_addr[0 +: AW] = 5'd7; req_wdata[0 +: W] = 8'h3C; req_addr[AW +: AW] = 5'd9;
    #1;
    check("cc_ready",  32'(req_ready), 32'h3);
    check("cc_wena",   32'(ram_wr_ena), 32'h1);
    check("cc_wraddr", 32'(ram_wr_addr), 32'd7);
    check("cc_wrdata", 32'(ram_wr_data), 32'h3C);
    check("cc_rdaddr", 32'(ram_rd_addr), 32'd9);
    tick();
    check("cc_rspv", 32'(rsp_valid), 32'h2);
    req_valid = 2'b01; req_we = 2'b00;
    #1;
    check("cc_rb_ready", 32'(req_ready), 32'h1);
    tick();
    check("cc_rb_rspv", 32'(rsp_valid), 32'h1);
    check("cc_rb_rspd", 32'(rsp_data), 32'h3C);

    // Same-address collision on row 4
    req_valid = 2'b11; req_we = 2'b01;
    req_addr[0 +: AW] = 5'd4; req_wdata[0 +: W] = 8'h22; req_addr[AW +: AW] = 5'd4;
    #1;
    check("col_ready", 32'(req_ready), 32'h3);
    tick();
    check("col_rspv", 32'(rsp_valid), 32'h2);
    check("col_rspd", 32'(rsp_data), 32'(coll_exp));
    req_valid = 2'b10; req_we = 2'b00;
    #1;
    check("col_rb_ready", 32'(req_ready), 32'h2);
    tick();
    check("col_rb_rspv", 32'(rsp_valid), 32'h2);
    check("col_rb_rspd", 32'(rsp_data), 32'h22);

    // Write fairness: wr_ptr is 1 here, so requester 1 goes first
    req_valid = 2'b11; req_we = 2'b11;
    req_addr[0 +: AW] = 5'd10; req_wdata[0 +: W] = 8'hA0;
    req_addr[AW +: AW] = 5'd11; req_wdata[W +: W] = 8'hA1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("wf_ready",  32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h1);
      check("wf_wraddr", 32'(ram_wr_addr), (k % 2 == 0) ? 32'd11 : 32'd10);
      check("wf_wrdata", 32'(ram_wr_data), (k % 2 == 0) ? 32'hA1 : 32'hA0);
      tick();
      check("wf_rspv", 32'(rsp_valid), 32'h0);
    end

    // Reset mid-read: requester 0 reads, requester 1 writes
    req_valid = 2'b11; req_we = 2'b10;
    req_addr[0 +: AW] = 5'd1; req_addr[AW +: AW] = 5'd20; req_wdata[W +: W] = 8'h77;
    #1;
    check("mr_ready", 32'(req_ready), 32'h3);
    check("mr_wena",  32'(ram_wr_ena), 32'h1);
    tick();
    check("mr_rspv", 32'(rsp_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("mr_rst_ready", 32'(req_ready), 32'h0);
    check("mr_rst_wena",  32'(ram_wr_ena), 32'h0);
    check("mr_rst_rspv",  32'(rsp_valid), 32'h0);
    check("mr_rst_rspd",  32'(rsp_data), 32'h0);
    tick();
    rst = 1'b0;
    req_we = 2'b00; req_addr[AW +: AW] = 5'd2;
    #1;
    check("post_rst_rspv",  32'(rsp_valid), 32'h0);
    check("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    check("post_rst_rsp_v", 32'(rsp_valid), 32'h1);
    check("post_rst_rspd",  32'(rsp_data), 32'hB1);

    req_valid = 2'b00;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
